// File: rtl/ifu_prefetch.sv
// Prefetching instruction fetch unit: pipelined word fetches into an in-order FIFO,
// stalls after control flow and resumes on a BU redirect. Option: IFU_JUMP_STALL_EN.
package ifu_prefetch_pkg;
  typedef enum logic [2:0] {
    FU_ALU = 3'd0,
    FU_BU  = 3'd1,
    FU_LSU = 3'd2,
    FU_MUL = 3'd3,
    FU_DIV = 3'd4
  } e_functional_unit;
endpackage

module ifu_prefetch
  import ifu_prefetch_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 64,
  parameter int unsigned FETCH_DEPTH = 4,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     req_valid_o,
  output logic [ADDRESS_WIDTH-1:0] req_addr_o,
  input  logic                     req_ready_i,
  input  logic                     resp_valid_i,
  input  logic [31:0]              resp_data_i,
  input  logic                     instruction_poll_i,
  output logic                     fetch_ready_o,
  output logic [31:0]              fetch_insn_o,
  output logic [ADDRESS_WIDTH-1:0] fetch_pc_o,
  input  logic                     bcast_valid_i,
  input  logic [ADDRESS_WIDTH-1:0] bcast_value_i,
  input  e_functional_unit         bcast_rs_i
);

  localparam int unsigned PW = $clog2(FETCH_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(FETCH_DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] WORD_STEP = ADDRESS_WIDTH'(4);

  typedef enum logic {S_RUN, S_WAIT} state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d, fifo_pc_q, fifo_pc_d;
  logic [CW-1:0]            count_q, count_d, inflight_q, inflight_d, drop_q, drop_d;
  logic [PW-1:0]            rd_q, rd_d, wr_q, wr_d;
  logic                     req_valid_q, req_valid_d, ready_q;
  logic [31:0]              insn_mem [FETCH_DEPTH];
  logic [ADDRESS_WIDTH-1:0] pc_mem   [FETCH_DEPTH];

  logic                     redirect, issue, accept, pop, cf_hit;
  logic [ADDRESS_WIDTH-1:0] target;
  logic                     unused_ok;

  assign redirect  = bcast_valid_i && (bcast_rs_i == FU_BU);
  assign target    = {bcast_value_i[ADDRESS_WIDTH-1:2], 2'b00};
  assign issue     = req_valid_q && req_ready_i;
  assign accept    = resp_valid_i && !redirect && (drop_q == '0);
  assign pop       = instruction_poll_i && (count_q != '0) && !redirect;
  assign unused_ok = &{1'b0, bcast_value_i[1:0]};

  // Control-flow opcodes that stop sequential fetch
`ifdef IFU_JUMP_STALL_EN
  assign cf_hit = accept && ((resp_data_i[6:0] == 7'b1100011) ||
                             (resp_data_i[6:0] == 7'b1101111) ||
                             (resp_data_i[6:0] == 7'b1100111));
`else
  assign cf_hit = accept && (resp_data_i[6:0] == 7'b1100011);
`endif

  assign req_valid_o   = req_valid_q;
  assign req_addr_o    = pc_q;
  assign fetch_ready_o = ready_q;
  assign fetch_insn_o  = insn_mem[rd_q];
  assign fetch_pc_o    = pc_mem[rd_q];

  // Next-state: redirect overrides response/stall handling, which overrides pop/issue
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fifo_pc_d  = fifo_pc_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    drop_d     = drop_q;
    inflight_d = inflight_q + CW'(issue) - CW'(resp_valid_i);
    count_d    = count_q + CW'(accept) - CW'(pop);

    if (issue) pc_d = pc_q + WORD_STEP;
    if (resp_valid_i && (drop_q != '0)) drop_d = drop_q - CW'(1);
    if (accept) begin
      wr_d      = wr_q + PW'(1);
      fifo_pc_d = fifo_pc_q + WORD_STEP;
    end
    // Everything still outstanding after a control-flow insn is wrong-path
    if (cf_hit) begin
      state_d = S_WAIT;
      drop_d  = inflight_d;
    end
    if (pop) rd_d = rd_q + PW'(1);

    if (redirect) begin
      state_d   = S_RUN;
      pc_d      = target;
      fifo_pc_d = target;
      count_d   = '0;
      rd_d      = '0;
      wr_d      = '0;
      drop_d    = inflight_d;
    end

    req_valid_d = (state_d == S_RUN) &&
                  (({1'b0, count_d} + {1'b0, inflight_d}) < DEPTH_V);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      pc_q        <= RESET_PC;
      fifo_pc_q   <= RESET_PC;
      count_q     <= '0;
      inflight_q  <= '0;
      drop_q      <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
      req_valid_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fifo_pc_q   <= fifo_pc_d;
      count_q     <= count_d;
      inflight_q  <= inflight_d;
      drop_q      <= drop_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      req_valid_q <= req_valid_d;
      ready_q     <= (count_d != '0);
    end
  end

  // FIFO storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FETCH_DEPTH; i++) begin
        insn_mem[i] <= '0;
        pc_mem[i]   <= RESET_PC;
      end
    end else if (accept) begin
      insn_mem[wr_q] <= resp_data_i;
      pc_mem[wr_q]   <= fifo_pc_q;
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Randomized bench for ifu_prefetch: in-order memory with random latency, and a
// program-order reference model (epochs, stall flag, expected delivery queue).
module tb_ifu_prefetch;
  import ifu_prefetch_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned NCYC  = 4000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_o;
  logic [63:0] req_addr_o;
  logic        req_ready_i = 1'b0;
  logic        resp_valid_i = 1'b0;
  logic [31:0] resp_data_i = '0;
  logic        instruction_poll_i = 1'b0;
  logic        fetch_ready_o;
  logic [31:0] fetch_insn_o;
  logic [63:0] fetch_pc_o;
  logic        bcast_valid_i = 1'b0;
  logic [63:0] bcast_value_i = '0;
  e_functional_unit bcast_rs_i = FU_ALU;

  ifu_prefetch dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_o(req_valid_o), .req_addr_o(req_addr_o), .req_ready_i(req_ready_i),
    .resp_valid_i(resp_valid_i), .resp_data_i(resp_data_i),
    .instruction_poll_i(instruction_poll_i),
    .fetch_ready_o(fetch_ready_o), .fetch_insn_o(fetch_insn_o), .fetch_pc_o(fetch_pc_o),
    .bcast_valid_i(bcast_valid_i), .bcast_value_i(bcast_value_i), .bcast_rs_i(bcast_rs_i)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] addr; int unsigned epoch; int unsigned due; } req_t;
  typedef struct { logic [63:0] pc; logic [31:0] insn; } ent_t;

  req_t        pend[$];
  ent_t        expq[$];
  int unsigned epoch;
  bit          stalled;
  logic [63:0] next_addr;
  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Program image: deterministic per address, mix of branches, jumps and ALU ops
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] h;
    logic [6:0]  op;
    h = (a[31:0] ^ a[63:32]) * 32'h9E37_79B1;
    case (h[31:28])
      4'd0, 4'd1: op = 7'b1100011;
      4'd2:       op = 7'b1101111;
      4'd3:       op = 7'b1100111;
      default:    op = 7'b0010011;
    endcase
    return {h[24:0], op};
  endfunction

  function automatic bit is_cf(input logic [31:0] w);
`ifdef IFU_JUMP_STALL_EN
    return (w[6:0] == 7'b1100011) || (w[6:0] == 7'b1101111) || (w[6:0] == 7'b1100111);
`else
    return w[6:0] == 7'b1100011;
`endif
  endfunction

  task automatic model_reset();
    pend.delete();
    expq.delete();
    epoch     = 0;
    stalled   = 0;
    next_addr = 64'h0;
  endtask

  task automatic idle_inputs();
    req_ready_i        = 1'b0;
    resp_valid_i       = 1'b0;
    instruction_poll_i = 1'b0;
    bcast_valid_i      = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rst_req_valid", req_valid_o, 1'b0);
    check("rst_req_addr", req_addr_o, 64'h0);
    check("rst_fetch_ready", fetch_ready_o, 1'b0);
    check("rst_fetch_insn", fetch_insn_o, 32'h0);
    check("rst_fetch_pc", fetch_pc_o, 64'h0);
  endtask

  initial begin
    bit          redirect, hs, exp_rv;
    int unsigned rdy_pct, poll_pct, bu_pct, r;
    req_t        rq;
    logic [31:0] w;

    model_reset();
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
    @(posedge clk);

    for (int unsigned c = 0; c < NCYC; c++) begin
      // Asynchronous reset in the middle of traffic
      if (c == NCYC / 2) begin
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        #1;
        check_reset_values();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
      end

      @(negedge clk);
      exp_rv = !stalled && ((expq.size() + pend.size()) < DEPTH);
      check("req_valid", req_valid_o, exp_rv);
      check("req_addr", req_addr_o, next_addr);
      check("fetch_ready", fetch_ready_o, expq.size() != 0);
      if (expq.size() != 0) begin
        check("fetch_pc", fetch_pc_o, expq[0].pc);
        check("fetch_insn", fetch_insn_o, expq[0].insn);
      end

      case ((c / 500) % 4)
        0: begin rdy_pct = 90; poll_pct = 10; end
        1: begin rdy_pct = 50; poll_pct = 60; end
        2: begin rdy_pct = 100; poll_pct = 95; end
        default: begin rdy_pct = 30; poll_pct = 30; end
      endcase
      req_ready_i        = ($urandom_range(0, 99) < rdy_pct);
      instruction_poll_i = ($urandom_range(0, 99) < poll_pct);
      if (pend.size() != 0 && pend[0].due <= c) begin
        resp_valid_i = 1'b1;
        resp_data_i  = mem_word(pend[0].addr);
      end else begin
        resp_valid_i = 1'b0;
        resp_data_i  = $urandom;
      end
      bu_pct = stalled ? 15 : 2;
      r = $urandom_range(0, 99);
      bcast_valid_i = (r < bu_pct + 5);
      bcast_rs_i    = (r < bu_pct) ? FU_BU
                                   : e_functional_unit'(3'($urandom_range(2, 4)));
      if ($urandom_range(0, 7) == 0)
        bcast_value_i = 64'hFFFF_FFFF_FFFF_FFE0 | 64'($urandom_range(0, 31));
      else
        bcast_value_i = 64'($urandom_range(0, 4095));

      // Reference update for the coming edge
      redirect = bcast_valid_i && (bcast_rs_i == FU_BU);
      hs       = req_valid_o && req_ready_i;
      if (!redirect && instruction_poll_i && expq.size() != 0) void'(expq.pop_front());
      if (resp_valid_i) begin
        rq = pend.pop_front();
        if (!redirect && rq.epoch == epoch && !stalled) begin
          w = mem_word(rq.addr);
          expq.push_back('{pc: rq.addr, insn: w});
          if (is_cf(w)) stalled = 1;
        end
      end
      if (hs) begin
        pend.push_back('{addr: next_addr, epoch: epoch, due: c + $urandom_range(1, 3)});
        next_addr = next_addr + 64'd4;
      end
      if (redirect) begin
        expq.delete();
        epoch++;
        stalled   = 0;
        next_addr = {bcast_value_i[63:2], 2'b00};
      end

      @(posedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
